// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: shared types and constants for the SRAM port arbiter.
package sram_arb_pkg;
  localparam int STARVE_CNT_WIDTH = 4;
  typedef enum logic {OWNER_DATA, OWNER_FETCH} owner_t;
  typedef struct packed {
    logic   valid;
    owner_t owner;
  } rsp_tag_t;
endpackage

// File: rtl/sram_arb_tag_pipe.sv
// sram_arb_tag_pipe: DEPTH-deep shift register of response tags, cleared by rst_n.
module sram_arb_tag_pipe
  import sram_arb_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic     clk,
  input  logic     rst_n,
  input  rsp_tag_t tag_in,
  output rsp_tag_t tag_out
);
  rsp_tag_t [DEPTH-1:0] pipe_q, pipe_d;
  always_comb begin
    pipe_d = pipe_q;
    pipe_d[0] = tag_in;
    for (int k = 1; k < DEPTH; k++) pipe_d[k] = pipe_q[k-1];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pipe_q <= '0;
    else pipe_q <= pipe_d;
  end
  assign tag_out = pipe_q[DEPTH-1];
endmodule

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one SRAM port between the data port and fetch, data-first with starvation guard.
// Define SRAM_ARB_PERF_COUNTERS_EN to add the conflict_count/force_count ports.
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    d_req_valid,
  output logic                    d_req_ready,
  input  logic [ADDR_WIDTH-1:0]   d_req_addr,
  input  logic                    d_req_we,
  input  logic [DATA_WIDTH/8-1:0] d_req_be,
  input  logic [DATA_WIDTH-1:0]   d_req_wdata,
  output logic                    d_rsp_valid,
  output logic [DATA_WIDTH-1:0]   d_rsp_rdata,
  input  logic                    i_req_valid,
  output logic                    i_req_ready,
  input  logic [ADDR_WIDTH-1:0]   i_req_addr,
  output logic                    i_rsp_valid,
  output logic [DATA_WIDTH-1:0]   i_rsp_rdata,
  output logic [ADDR_WIDTH-1:0]   mem_address,
  output logic                    mem_write_enable,
  output logic [DATA_WIDTH/8-1:0] mem_byte_enable,
  output logic [DATA_WIDTH-1:0]   mem_write_data,
`ifdef SRAM_ARB_PERF_COUNTERS_EN
  output logic [31:0]             conflict_count,
  output logic [31:0]             force_count,
`endif
  input  logic [DATA_WIDTH-1:0]   mem_read_data
);
  logic [STARVE_CNT_WIDTH-1:0] starve_cnt_q, starve_cnt_d;
  logic force_i, grant_i, grant_d;
  rsp_tag_t push_tag, tail_tag;
  always_comb begin
    force_i = starve_cnt_q == STARVE_CNT_WIDTH'(STARVE_LIMIT);
    grant_i = i_req_valid & (~d_req_valid | force_i);
    grant_d = d_req_valid & ~grant_i;
    d_req_ready = grant_d;
    i_req_ready = grant_i;
    mem_address = grant_i ? i_req_addr : grant_d ? d_req_addr : '0;
    mem_write_enable = grant_d & d_req_we;
    mem_byte_enable = grant_i ? '1 : grant_d ? d_req_be : '0;
    mem_write_data = grant_d ? d_req_wdata : '0;
    starve_cnt_d = (i_req_valid & ~grant_i)
                 ? (force_i ? starve_cnt_q : starve_cnt_q + STARVE_CNT_WIDTH'(1)) : '0;
    push_tag.valid = grant_i | (grant_d & ~d_req_we);
    push_tag.owner = grant_i ? OWNER_FETCH : OWNER_DATA;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) starve_cnt_q <= '0;
    else starve_cnt_q <= starve_cnt_d;
  end
  sram_arb_tag_pipe #(.DEPTH(READ_LATENCY)) u_tag_pipe (
    .clk(clk),
    .rst_n(rst_n),
    .tag_in(push_tag),
    .tag_out(tail_tag)
  );
  assign d_rsp_valid = tail_tag.valid & (tail_tag.owner == OWNER_DATA);
  assign i_rsp_valid = tail_tag.valid & (tail_tag.owner == OWNER_FETCH);
  assign d_rsp_rdata = mem_read_data;
  assign i_rsp_rdata = mem_read_data;
`ifdef SRAM_ARB_PERF_COUNTERS_EN
  logic [31:0] conflict_count_q, conflict_count_d, force_count_q, force_count_d;
  always_comb begin
    conflict_count_d = conflict_count_q + 32'(d_req_valid & i_req_valid);
    force_count_d = force_count_q + 32'(grant_i & force_i & d_req_valid);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_count_q <= '0;
      force_count_q <= '0;
    end else begin
      conflict_count_q <= conflict_count_d;
      force_count_q <= force_count_d;
    end
  end
  assign conflict_count = conflict_count_q;
  assign force_count = force_count_q;
`endif
endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: directed checks of arbitration, starvation, store/load and response routing.
// Two instances share stimulus: READ_LATENCY 1 (dut1) and 3 (dut3).
module tb_sram_port_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic        d_req_valid, d_req_we, i_req_valid;
  logic [31:0] d_req_addr, d_req_wdata, i_req_addr;
  logic [3:0]  d_req_be;
  logic        d_req_ready, i_req_ready, d_rsp_valid, i_rsp_valid, mem_write_enable;
  logic [31:0] d_rsp_rdata, i_rsp_rdata, mem_address, mem_write_data;
  logic [3:0]  mem_byte_enable;
  logic        r3_d_req_ready, r3_i_req_ready, r3_d_rsp_valid, r3_i_rsp_valid, r3_we;
  logic [31:0] r3_d_rsp_rdata, r3_i_rsp_rdata, r3_addr, r3_wdata;
  logic [3:0]  r3_be;
`ifdef SRAM_ARB_PERF_COUNTERS_EN
  logic [31:0] conflict_count, force_count, r3_conflict_count, r3_force_count;
`endif
  logic [31:0] mem [256] = '{default: '0};
  logic [31:0] rd1;
  logic [31:0] rd3 [3];
  always @(posedge clk) begin
    rd1 <= mem[mem_address[9:2]];
    rd3[0] <= mem[r3_addr[9:2]];
    rd3[1] <= rd3[0];
    rd3[2] <= rd3[1];
    if (mem_write_enable)
      for (int b = 0; b < 4; b++)
        if (mem_byte_enable[b]) mem[mem_address[9:2]][8*b +: 8] <= mem_write_data[8*b +: 8];
  end
  sram_port_arbiter #(.READ_LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
    .d_req_we(d_req_we), .d_req_be(d_req_be), .d_req_wdata(d_req_wdata),
    .d_rsp_valid(d_rsp_valid), .d_rsp_rdata(d_rsp_rdata),
    .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
    .i_rsp_valid(i_rsp_valid), .i_rsp_rdata(i_rsp_rdata),
    .mem_address(mem_address), .mem_write_enable(mem_write_enable),
    .mem_byte_enable(mem_byte_enable), .mem_write_data(mem_write_data),
`ifdef SRAM_ARB_PERF_COUNTERS_EN
    .conflict_count(conflict_count), .force_count(force_count),
`endif
    .mem_read_data(rd1)
  );
  sram_port_arbiter #(.READ_LATENCY(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .d_req_valid(d_req_valid), .d_req_ready(r3_d_req_ready), .d_req_addr(d_req_addr),
    .d_req_we(d_req_we), .d_req_be(d_req_be), .d_req_wdata(d_req_wdata),
    .d_rsp_valid(r3_d_rsp_valid), .d_rsp_rdata(r3_d_rsp_rdata),
    .i_req_valid(i_req_valid), .i_req_ready(r3_i_req_ready), .i_req_addr(i_req_addr),
    .i_rsp_valid(r3_i_rsp_valid), .i_rsp_rdata(r3_i_rsp_rdata),
    .mem_address(r3_addr), .mem_write_enable(r3_we),
    .mem_byte_enable(r3_be), .mem_write_data(r3_wdata),
`ifdef SRAM_ARB_PERF_COUNTERS_EN
    .conflict_count(r3_conflict_count), .force_count(r3_force_count),
`endif
    .mem_read_data(rd3[2])
  );
  int checks = 0;
  int errors = 0;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    d_req_valid = 1'b0;
    i_req_valid = 1'b0;
    d_req_we = 1'b0;
    d_req_be = '0;
    d_req_wdata = '0;
  endtask
  task automatic dreq(input logic we, input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wdata);
    d_req_valid = 1'b1;
    d_req_we = we;
    d_req_addr = addr;
    d_req_be = be;
    d_req_wdata = wdata;
  endtask
  task automatic ireq(input logic [31:0] addr);
    i_req_valid = 1'b1;
    i_req_addr = addr;
  endtask
  logic [31:0] alt_addr [4] = '{32'h100, 32'h104, 32'h104, 32'h100};
  logic [31:0] alt_data [4] = '{32'hA1A1A1A1, 32'hB2B2B2B2, 32'hB2B2B2B2, 32'hA1A1A1A1};
  initial begin
    idle();
    d_req_addr = '0;
    i_req_addr = '0;
    #3;
    check("rst_d_ready", d_req_ready, 0);
    check("rst_i_ready", i_req_ready, 0);
    check("rst_mem_we", mem_write_enable, 0);
    check("rst_mem_addr", mem_address, 0);
    check("rst_mem_be", mem_byte_enable, 0);
    check("rst_mem_wdata", mem_write_data, 0);
    check("rst_d_rsp", d_rsp_valid, 0);
    check("rst_i_rsp", i_rsp_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    dreq(1'b1, 32'h100, 4'hF, 32'hA1A1A1A1);
    #3;
    check("pre_we", mem_write_enable, 1);
    check("pre_be", mem_byte_enable, 4'hF);
    cyc();
    dreq(1'b1, 32'h104, 4'hF, 32'hB2B2B2B2);
    #3;
    check("pre_d_ready", d_req_ready, 1);
    cyc();
    idle();
    #3;
    check("store_no_rsp", d_rsp_valid, 0);
    cyc();
    ireq(32'h100);
    #3;
    check("f1_i_ready", i_req_ready, 1);
    check("f1_d_ready", d_req_ready, 0);
    check("f1_addr", mem_address, 32'h100);
    check("f1_be", mem_byte_enable, 4'hF);
    check("f1_we", mem_write_enable, 0);
    cyc();
    ireq(32'h104);
    #3;
    check("f2_i_ready", i_req_ready, 1);
    check("f2_i_rsp", i_rsp_valid, 1);
    check("f2_rdata", i_rsp_rdata, 32'hA1A1A1A1);
    check("f2_d_rsp", d_rsp_valid, 0);
    cyc();
    idle();
    #3;
    check("f3_i_rsp", i_rsp_valid, 1);
    check("f3_rdata", i_rsp_rdata, 32'hB2B2B2B2);
    cyc();
    #3;
    check("f4_i_rsp", i_rsp_valid, 0);
    cyc();
    dreq(1'b0, 32'h104, 4'h0, 32'h0);
    ireq(32'h100);
    #3;
    check("both_d_ready", d_req_ready, 1);
    check("both_i_ready", i_req_ready, 0);
    check("both_addr", mem_address, 32'h104);
    cyc();
    idle();
    #3;
    check("both_d_rsp", d_rsp_valid, 1);
    check("both_rdata", d_rsp_rdata, 32'hB2B2B2B2);
    check("both_i_rsp", i_rsp_valid, 0);
    cyc();
    #3;
    check("both_d_rsp_end", d_rsp_valid, 0);
    cyc();
    dreq(1'b0, 32'h100, 4'h0, 32'h0);
    ireq(32'h104);
    for (int k = 0; k < 4; k++) begin
      #3;
      check("starve_d_ready", d_req_ready, 1);
      check("starve_i_ready", i_req_ready, 0);
      cyc();
    end
    #3;
    check("force_i_ready", i_req_ready, 1);
    check("force_d_ready", d_req_ready, 0);
    check("force_addr", mem_address, 32'h104);
    cyc();
    #3;
    check("after_d_ready", d_req_ready, 1);
    check("after_i_ready", i_req_ready, 0);
    check("after_starve", dut1.starve_cnt_q, 0);
`ifdef SRAM_ARB_PERF_COUNTERS_EN
    check("perf_force", force_count, 1);
    check("perf_conflict", conflict_count, 6);
`endif
    cyc();
    idle();
    cyc();
    dreq(1'b1, 32'h40, 4'b0011, 32'hDEADBEEF);
    #3;
    check("st_we", mem_write_enable, 1);
    check("st_be", mem_byte_enable, 4'b0011);
    check("st_wdata", mem_write_data, 32'hDEADBEEF);
    check("st_addr", mem_address, 32'h40);
    cyc();
    dreq(1'b0, 32'h40, 4'h0, 32'h0);
    #3;
    check("ld_we", mem_write_enable, 0);
    check("st_no_rsp", d_rsp_valid, 0);
    cyc();
    idle();
    #3;
    check("ld_rsp", d_rsp_valid, 1);
    check("ld_rdata", d_rsp_rdata, 32'h0000BEEF);
    repeat (3) cyc();
    for (int k = 0; k < 8; k++) begin
      logic ed, ei;
      idle();
      if (k < 4) begin
        if (k % 2 == 0) dreq(1'b0, alt_addr[k], 4'h0, 32'h0);
        else ireq(alt_addr[k]);
      end
      ed = (k >= 3) && (k <= 6) && ((k - 3) % 2 == 0);
      ei = (k >= 3) && (k <= 6) && ((k - 3) % 2 == 1);
      #3;
      check("rl3_d_valid", r3_d_rsp_valid, ed);
      check("rl3_i_valid", r3_i_rsp_valid, ei);
      if (ed) check("rl3_d_rdata", r3_d_rsp_rdata, alt_data[k-3]);
      if (ei) check("rl3_i_rdata", r3_i_rsp_rdata, alt_data[k-3]);
      cyc();
    end
    idle();
    ireq(32'h100);
    #3;
    check("mid_i_ready", i_req_ready, 1);
    cyc();
    dreq(1'b0, 32'h104, 4'h0, 32'h0);
    #3;
    check("mid_d_ready", d_req_ready, 1);
    cyc();
    check("mid_starve", dut1.starve_cnt_q, 1);
    rst_n = 1'b0;
    idle();
    #1;
    check("rst_starve", dut1.starve_cnt_q, 0);
    check("rst_d_rsp1", d_rsp_valid, 0);
    check("rst_r3_i_rsp", r3_i_rsp_valid, 0);
`ifdef SRAM_ARB_PERF_COUNTERS_EN
    check("rst_conflict", conflict_count, 0);
    check("rst_force", force_count, 0);
`endif
    repeat (2) cyc();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cyc();
      check("post_r3_i_rsp", r3_i_rsp_valid, 0);
      check("post_r3_d_rsp", r3_d_rsp_valid, 0);
      check("post_i_rsp", i_rsp_valid, 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
Shares the single-port data SRAM between two requesters: the memory stage (data port, read/write) and instruction fetch (read-only).
- At most one access is granted per cycle.
- Read responses return to the owning requester after a fixed SRAM latency.
- Fixed priority favours the data port; a starvation counter guarantees fetch progress.
- Sits between the fetch/memory stages and the SRAM port.

Parameters:
ADDR_WIDTH, 32, address width of both requesters and the SRAM port
DATA_WIDTH, 32, data width; multiple of 8
READ_LATENCY, 1, SRAM read latency in cycles; legal range 1..4
STARVE_LIMIT, 4, consecutive lost fetch cycles before fetch is forced to win; legal range 1..15

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous reset, active low
d_req_valid  in  1  data-port request valid
d_req_ready  out  1  data-port request accepted this cycle
d_req_addr  in  ADDR_WIDTH  data-port address
d_req_we  in  1  1 = store, 0 = load
d_req_be  in  DATA_WIDTH/8  store byte enables
d_req_wdata  in  DATA_WIDTH  store data
d_rsp_valid  out  1  load data valid
d_rsp_rdata  out  DATA_WIDTH  load data
i_req_valid  in  1  fetch request valid
i_req_ready  out  1  fetch request accepted this cycle
i_req_addr  in  ADDR_WIDTH  fetch address
i_rsp_valid  out  1  fetch data valid
i_rsp_rdata  out  DATA_WIDTH  fetch data
mem_address  out  ADDR_WIDTH  SRAM address
mem_write_enable  out  1  SRAM write strobe
mem_byte_enable  out  DATA_WIDTH/8  SRAM byte enables
mem_write_data  out  DATA_WIDTH  SRAM write data
mem_read_data  in  DATA_WIDTH  SRAM read data, valid READ_LATENCY cycles after address

Behaviour:
- Reset (rst_n low, asynchronous):
  - All tag-pipe stages invalid; starve_cnt = 0.
  - d_rsp_valid = i_rsp_valid = 0.
  - Combinational outputs with no valid requests: readys = 0, mem_write_enable = 0, mem_address = 0, mem_byte_enable = 0, mem_write_data = 0.
- Grant logic, combinational, no registered state except starve_cnt:
  - force_i = (starve_cnt == STARVE_LIMIT).
  - grant_i = i_req_valid & (~d_req_valid | force_i).
  - grant_d = d_req_valid & ~grant_i.
  - d_req_ready = grant_d; i_req_ready = grant_i.
  - A ready never depends on its own valid beyond the gating above. The handshake completes in the same cycle.
- SRAM drive:
  - Granted requester's address/be/wdata are muxed onto the SRAM port.
  - mem_write_enable = grant_d & d_req_we.
  - Fetch reads drive mem_byte_enable all-ones.
  - No grant: mem_write_enable = 0 and the other fields are 0.
- Starvation counter:
  - Increments when i_req_valid & ~grant_i.
  - Clears to 0 on grant_i or when ~i_req_valid.
  - Saturates at STARVE_LIMIT.
  - When force_i is asserted and both request, fetch wins and the data port stalls exactly one cycle.
- Response tag pipe:
  - Depth READ_LATENCY. Each entry holds {valid, owner}.
  - A stage-0 entry is pushed each cycle: valid = grant_i | (grant_d & ~d_req_we); owner = FETCH if grant_i, else DATA.
  - At the tail: d_rsp_valid = tail.valid & owner == DATA; i_rsp_valid = tail.valid & owner == FETCH.
  - Both rdata outputs are mem_read_data.
  - Stores generate no response; a store is complete at its handshake.
  - Responses have no backpressure. Requesters must accept them.
- Throughput: back-to-back grants every cycle; tags for consecutive reads are independent.
- Reset mid-operation: in-flight tags are discarded and no response is delivered for them. Requesters must reissue.
- Simultaneous store and fetch with force_i = 0: the store wins and fetch waits; starve_cnt increments.

Optional Feature:
Macro: SRAM_ARB_PERF_COUNTERS_EN
- Defined:
  - Adds ports conflict_count (out, 32) and force_count (out, 32), both reset to 0.
  - conflict_count increments each cycle both valids are high.
  - force_count increments each cycle grant_i occurs with force_i = 1 and d_req_valid = 1.
  - Both counters wrap at 2^32.
- Undefined: these ports and registers do not exist. Arbitration behaviour is identical in both builds.

Decomposition:
- Package sram_arb_pkg:
  - owner_t enum {OWNER_DATA, OWNER_FETCH}.
  - rsp_tag_t struct {logic valid; owner_t owner}.
  - Localparam STARVE_CNT_WIDTH = 4.
- Sub-module sram_arb_tag_pipe: a parameterised READ_LATENCY-deep shift register of rsp_tag_t with async active-low clear.

Test Plan:
- Fetch-only reads at addr 0x100, 0x104, READ_LATENCY = 1 -> i_req_ready = 1 each cycle; i_rsp_valid one cycle later; rdata matches SRAM model at each address.
- Data load and fetch both valid at cycle N, starve_cnt = 0 -> d_req_ready = 1, i_req_ready = 0; d_rsp_valid at N+1 only.
- d_req_valid held high continuously with STARVE_LIMIT = 4 while fetch waits -> fetch granted on the 5th cycle; data stalled exactly that cycle; starve_cnt back to 0.
- Store 0xDEADBEEF to 0x40 with be = 4'b0011, then load 0x40 -> mem_write_enable pulses once; no d_rsp for the store; load returns 0x0000BEEF over a zero-initialised word.
- READ_LATENCY = 3, alternating data-load/fetch grants every cycle -> responses are routed to the correct owner 3 cycles after each grant, in order.
- rst_n asserted low one cycle after a granted read -> rsp_valid never asserts for that read; starve_cnt = 0. With SRAM_ARB_PERF_COUNTERS_EN defined, the counters read 0.
